// File: rtl/axi4_burst_checker.sv
// -----------------------------------------------------------------------------
// axi4_burst_checker
//   AXI4 self-test master. For each accepted command it writes one INCR burst
//   of the pattern (seed + beat index), then reads the same range back and
//   compares every beat against the same pattern. Data mismatches are counted
//   (saturating at 256). Rejected commands, non-OKAY responses and a misplaced
//   or missing RLAST are flagged in resp_err. Both results hold until the next
//   command is accepted.
//
//   Commands are rejected without any bus activity if the base address is not
//   beat-aligned or if the burst would cross a 4 KB boundary.
//
// Ports
//   ACLK, ARESETn                   clock (rising edge), async active-low reset
//   cmd_valid/addr/len/seed         command; accepted only while idle
//   busy                            command in progress (through the done cycle)
//   done                            one-cycle pulse at command end
//   err_cnt                         data mismatches of the last command
//   resp_err                        reject / error response / RLAST problem
//   AW*, W*, B*, AR*, R*            AXI4 master channels (INCR, fixed size)
// -----------------------------------------------------------------------------
module axi4_burst_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  output logic                  busy,
  output logic                  done,
  output logic [8:0]            err_cnt,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam int unsigned           BYTES  = DATA_WIDTH / 8;
  localparam logic [2:0]            SIZE   = 3'($clog2(BYTES));
  localparam logic [DATA_WIDTH-1:0] ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [8:0]            ERRMAX = 9'd256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [DATA_WIDTH-1:0] r_data;   // current write beat, later the expected read beat
  logic [7:0]            r_beat;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_wlast;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_resp_err;
  logic [8:0]            r_err_cnt;

  // Reject decode: only the offset inside the 4 KB page matters.
  logic [11:0] w_off;
  logic [31:0] w_end;
  logic        w_misaligned;
  logic        w_cross;
  logic        w_reject;
  logic        w_rlast_due;

  assign w_off        = cmd_addr[11:0];
  assign w_end        = 32'(w_off) + (32'(cmd_len) + 32'd1) * BYTES - 32'd1;
  assign w_misaligned = (32'(w_off) % BYTES) != 32'd0;
  assign w_cross      = w_end > 32'd4095;
  assign w_reject     = w_misaligned || w_cross;
  assign w_rlast_due  = (r_beat == r_len);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_seed     <= '0;
      r_data     <= '0;
      r_beat     <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_wlast    <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_resp_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr    <= cmd_addr;
            r_len     <= cmd_len;
            r_seed    <= cmd_seed;
            r_err_cnt <= '0;
            r_busy    <= 1'b1;
            if (w_reject) begin
              r_resp_err <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_resp_err <= 1'b0;
              r_awvalid  <= 1'b1;
              r_state    <= S_AW;
            end
          end
        end

        S_AW: begin
          if (AWREADY) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_data    <= r_seed;
            r_beat    <= '0;
            r_wlast   <= (r_len == 8'd0);
            r_state   <= S_W;
          end
        end

        // WVALID is high throughout this state, so WREADY alone is the handshake.
        S_W: begin
          if (WREADY) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end else begin
              r_data  <= r_data + ONE;
              r_beat  <= r_beat + 8'd1;
              r_wlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end

        S_B: begin
          if (BVALID) begin
            r_bready <= 1'b0;
            if (BRESP != 2'b00) begin
              r_resp_err <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end

        S_AR: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_data    <= r_seed;
            r_beat    <= '0;
            r_state   <= S_R;
          end
        end

        // RLAST must coincide exactly with the final expected beat; the burst
        // ends on whichever of the two arrives first.
        S_R: begin
          if (RVALID) begin
            if ((RDATA != r_data) && (r_err_cnt != ERRMAX)) begin
              r_err_cnt <= r_err_cnt + 9'd1;
            end
            if ((RRESP != 2'b00) || (RLAST != w_rlast_due)) begin
              r_resp_err <= 1'b1;
            end
            if (RLAST || w_rlast_due) begin
              r_rready <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_data <= r_data + ONE;
              r_beat <= r_beat + 8'd1;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err_cnt  = r_err_cnt;
  assign resp_err = r_resp_err;
  assign AWADDR   = r_addr;
  assign AWLEN    = r_len;
  assign AWSIZE   = SIZE;
  assign AWVALID  = r_awvalid;
  assign WDATA    = r_data;
  assign WLAST    = r_wlast;
  assign WVALID   = r_wvalid;
  assign BREADY   = r_bready;
  assign ARADDR   = r_addr;
  assign ARLEN    = r_len;
  assign ARSIZE   = SIZE;
  assign ARVALID  = r_arvalid;
  assign RREADY   = r_rready;

endmodule

// File: tb/tb_axi4_burst_checker.sv
// -----------------------------------------------------------------------------
// tb_axi4_burst_checker
//   Drives commands into axi4_burst_checker with a small AXI4 slave memory model
//   that can stall, corrupt read beats, return SLVERR on B, or end a read burst
//   early with RLAST. Each command record carries its hand-computed results.
// -----------------------------------------------------------------------------
module tb_axi4_burst_checker;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [7:0]    cmd_len   = '0;
  logic [DW-1:0] cmd_seed  = '0;
  logic          busy, done, resp_err;
  logic [8:0]    err_cnt;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4_burst_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .busy(busy), .done(done), .err_cnt(err_cnt), .resp_err(resp_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // ---------------- slave model configuration ----------------
  bit         cfg_stall        = 1'b0;
  logic [1:0] cfg_bresp        = 2'b00;
  int         cfg_corrupt_beat = -1;
  bit         cfg_corrupt_all  = 1'b0;
  int         cfg_early        = -1;

  logic [31:0] mem [0:16383];
  logic [31:0] wlog [0:4095];
  logic        wlast_log [0:4095];
  int          wn = 0, aw_seen = 0, ar_seen = 0;
  logic [15:0] last_awaddr = '0;
  logic [7:0]  last_awlen  = '0;
  logic [13:0] s_wptr, s_rptr;
  logic [7:0]  s_ridx, s_rlen;
  logic        s_ractive;
  logic        rgo = 1'b1;

  always @(negedge ACLK) rgo <= !cfg_stall || ($urandom_range(0, 2) != 0);

  function automatic logic [31:0] rd_beat(input logic [13:0] base, input logic [7:0] idx);
    logic [31:0] d;
    d = mem[base + 14'(idx)];
    if (cfg_corrupt_all || (int'(idx) == cfg_corrupt_beat)) d = d ^ 32'h0000_0100;
    return d;
  endfunction

  function automatic logic last_of(input logic [7:0] idx, input logic [7:0] len);
    return (idx == len) || (int'(idx) == cfg_early);
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWREADY <= 1'b0; WREADY <= 1'b0; ARREADY <= 1'b0;
      BVALID <= 1'b0; BRESP <= 2'b00;
      RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00; RLAST <= 1'b0;
      s_wptr <= '0; s_rptr <= '0; s_ridx <= '0; s_rlen <= '0; s_ractive <= 1'b0;
    end else begin
      AWREADY <= !cfg_stall || ($urandom_range(0, 1) == 1);
      WREADY  <= !cfg_stall || ($urandom_range(0, 1) == 1);
      ARREADY <= !cfg_stall || ($urandom_range(0, 1) == 1);
      if (AWVALID && AWREADY) begin
        s_wptr      <= AWADDR[15:2];
        aw_seen     <= aw_seen + 1;
        last_awaddr <= AWADDR;
        last_awlen  <= AWLEN;
      end
      if (WVALID && WREADY) begin
        mem[s_wptr]   <= WDATA;
        s_wptr        <= s_wptr + 14'd1;
        wlog[wn]      <= WDATA;
        wlast_log[wn] <= WLAST;
        wn            <= wn + 1;
        if (WLAST) begin
          BVALID <= 1'b1;
          BRESP  <= cfg_bresp;
        end
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        ar_seen   <= ar_seen + 1;
        s_ractive <= 1'b1;
        s_rptr    <= ARADDR[15:2];
        s_rlen    <= ARLEN;
        if (rgo) begin
          RVALID <= 1'b1;
          RDATA  <= rd_beat(ARADDR[15:2], 8'd0);
          RLAST  <= last_of(8'd0, ARLEN);
          s_ridx <= 8'd1;
        end else begin
          s_ridx <= 8'd0;
        end
      end else if (s_ractive) begin
        if (RVALID && RREADY && RLAST) begin
          RVALID    <= 1'b0;
          RLAST     <= 1'b0;
          s_ractive <= 1'b0;
        end else if (!RVALID || RREADY) begin
          if (rgo) begin
            RVALID <= 1'b1;
            RDATA  <= rd_beat(s_rptr, s_ridx);
            RLAST  <= last_of(s_ridx, s_rlen);
            s_ridx <= s_ridx + 8'd1;
          end else begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [31:0] seed;
    bit          stall;
    logic [1:0]  bresp;
    int          corrupt_beat;
    bit          corrupt_all;
    int          early_last;
    logic [8:0]  exp_err;
    bit          exp_resp;
    int          exp_aw;
    int          exp_ar;
    int          exp_cycles;   // 0: latency not checked
  } vec_t;

  task automatic run_vec(input int k, input vec_t v);
    int n, wn0, aw0, ar0, bad;
    logic [31:0] e;
    cfg_stall        = v.stall;
    cfg_bresp        = v.bresp;
    cfg_corrupt_beat = v.corrupt_beat;
    cfg_corrupt_all  = v.corrupt_all;
    cfg_early        = v.early_last;
    wn0 = wn; aw0 = aw_seen; ar0 = ar_seen;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len; cmd_seed = v.seed;
    @(posedge ACLK); n = 1; #1;
    cmd_valid = 1'b0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge ACLK); n++; #1;
    end
    chk($sformatf("v%0d done_seen", k), 64'(done), 64'd1);
    if (v.exp_cycles != 0) chk($sformatf("v%0d latency", k), 64'(n), 64'(v.exp_cycles));
    chk($sformatf("v%0d err_cnt", k), 64'(err_cnt), 64'(v.exp_err));
    chk($sformatf("v%0d resp_err", k), 64'(resp_err), 64'(v.exp_resp));
    chk($sformatf("v%0d aw_count", k), 64'(aw_seen - aw0), 64'(v.exp_aw));
    chk($sformatf("v%0d ar_count", k), 64'(ar_seen - ar0), 64'(v.exp_ar));
    if (v.exp_aw != 0) begin
      chk($sformatf("v%0d awaddr", k), 64'(last_awaddr), 64'(v.addr));
      chk($sformatf("v%0d awlen", k), 64'(last_awlen), 64'(v.len));
      chk($sformatf("v%0d w_beats", k), 64'(wn - wn0), 64'(int'(v.len) + 1));
      bad = 0;
      for (int i = 0; i <= int'(v.len); i++) begin
        e = v.seed + 32'(i);
        if (wlog[wn0 + i] !== e || wlast_log[wn0 + i] !== (i == int'(v.len))) bad++;
      end
      chk($sformatf("v%0d wdata_wlast_bad_beats", k), 64'(bad), 64'd0);
    end else begin
      chk($sformatf("v%0d no_w_beats", k), 64'(wn - wn0), 64'd0);
    end
    @(posedge ACLK); #1;
    chk($sformatf("v%0d done_pulse_end", k), 64'({done, busy}), 64'd0);
    chk($sformatf("v%0d err_cnt_held", k), 64'({err_cnt, resp_err}), 64'({v.exp_err, v.exp_resp}));
  endtask

  vec_t vecs [9];
  vec_t after_rst;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          addr      len    seed          stl bresp cb  all early  err   resp aw ar cyc
    vecs[0] = '{16'h0010, 8'd0,   32'hA5A5A5A5, 0, 2'b00, -1, 0, -1, 9'd0,   0, 1, 1, 6};
    vecs[1] = '{16'h0100, 8'd15,  32'hFFFFFFFE, 1, 2'b00, -1, 0, -1, 9'd0,   0, 1, 1, 0};
    vecs[2] = '{16'h0200, 8'd7,   32'h12345678, 0, 2'b00,  3, 0, -1, 9'd1,   0, 1, 1, 0};
    vecs[3] = '{16'h1000, 8'd255, 32'h00000000, 0, 2'b00, -1, 1, -1, 9'd256, 0, 1, 1, 0};
    vecs[4] = '{16'hFFF1, 8'd0,   32'h11111111, 0, 2'b00, -1, 0, -1, 9'd0,   1, 0, 0, 1};
    vecs[5] = '{16'h0FF8, 8'd3,   32'h22222222, 0, 2'b00, -1, 0, -1, 9'd0,   1, 0, 0, 1};
    vecs[6] = '{16'h7FFC, 8'd0,   32'h33333333, 0, 2'b10, -1, 0, -1, 9'd0,   1, 1, 0, 0};
    vecs[7] = '{16'h0300, 8'd4,   32'h44444444, 0, 2'b00, -1, 0,  2, 9'd0,   1, 1, 1, 0};
    vecs[8] = '{16'h0FF0, 8'd3,   32'hCAFEF00D, 1, 2'b00, -1, 0, -1, 9'd0,   0, 1, 1, 0};
    after_rst = '{16'h0500, 8'd2, 32'h00000055, 0, 2'b00, -1, 0, -1, 9'd0,   0, 1, 1, 0};

    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    chk("reset_ctrl", 64'({AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, busy, done, resp_err}), 64'd0);
    chk("reset_addr_len_err", 64'({AWADDR, AWLEN, ARADDR, ARLEN, err_cnt}), 64'd0);
    chk("reset_wdata", 64'(WDATA), 64'd0);
    chk("axsize", 64'({AWSIZE, ARSIZE}), 64'({3'd2, 3'd2}));
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

    // Asynchronous reset in the middle of a stalled write burst.
    cfg_stall = 1'b1; cfg_bresp = 2'b00; cfg_corrupt_beat = -1; cfg_corrupt_all = 1'b0; cfg_early = -1;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_addr = 16'h0400; cmd_len = 8'd31; cmd_seed = 32'h0000_1000;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (WVALID !== 1'b1 && n < 200) begin
      @(posedge ACLK); #1; n++;
    end
    repeat (2) @(posedge ACLK);
    #3;
    chk("rst_mid_burst_wvalid_before", 64'(WVALID), 64'd1);
    ARESETn = 1'b0;
    #1;
    chk("rst_mid_burst_ctrl", 64'({AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, busy, done, resp_err}), 64'd0);
    chk("rst_mid_burst_addr_len_err", 64'({AWADDR, AWLEN, err_cnt}), 64'd0);
    chk("rst_mid_burst_wdata", 64'(WDATA), 64'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    run_vec(9, after_rst);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
